cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer_pkg.sv | 49 ++++
 rtl/cycle_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_sequencer_pkg.sv
// Shared CPU definitions: T-state encoding used by the opcode decoder and the
// cycle sequencer, plus the address-source select codes.
package cycle_sequencer_pkg;

  typedef enum logic [5:0] {
    T0_FETCH  = 6'd0,
    T1_DECODE = 6'd1,
    T2_ZPG    = 6'd2,
    T2_ZPGXY  = 6'd3,
    T3_ZPGXY  = 6'd4,
    T2_ABS    = 6'd5,
    T3_ABS    = 6'd6,
    T2_ABSXY  = 6'd7,
    T3_ABSXY  = 6'd8,
    T4_ABSXY  = 6'd9,
    T2_PUSH   = 6'd10,
    T2_POP    = 6'd11,
    T3_POP    = 6'd12,
    T_RMW1    = 6'd13,
    T_RMW2    = 6'd14,
    T2_BRK    = 6'd16,
    T2_JSR    = 6'd17,
    T2_RTI    = 6'd18,
    T2_RTS    = 6'd19,
    T2_XIND   = 6'd20,
    T2_INDY   = 6'd21,
    T2_BRANCH = 6'd22,
    T2_JUMP   = 6'd23,
    T_JAM     = 6'd63
  } t_state_e;

  typedef enum logic [2:0] {
    ADDR_PC      = 3'd0,
    ADDR_ZP      = 3'd1,
    ADDR_ZP_IDX  = 3'd2,
    ADDR_ABS     = 3'd3,
    ADDR_ABS_IDX = 3'd4,
    ADDR_ABS_FIX = 3'd5,
    ADDR_STACK   = 3'd6
  } addr_sel_e;

  // Result of the final memory access of an addressing mode.
  typedef struct packed {
    logic     we;
    logic     last;
    t_state_e next;
  } data_cycle_t;

endpackage

// File: rtl/cycle_sequencer.sv
// 6502-style T-state sequencer: registered state, combinational bus strobes,
// with RDY stalling of read cycles and a halt state left only by reset.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rdy,
  input  logic [5:0] i_initial_state,
  input  logic       i_single_byte,
  input  logic       i_mem_read,
  input  logic       i_mem_write,
  input  logic       i_page_cross,
  output logic [5:0] o_state,
  output logic       o_sync,
  output logic       o_ir_load,
  output logic       o_pc_inc,
  output logic [2:0] o_addr_sel,
  output logic       o_we,
  output logic       o_sp_inc,
  output logic       o_sp_dec,
  output logic       o_last,
  output logic       o_jam
);

  t_state_e    state_q, state_d;
  addr_sel_e   addr_sel;
  addr_sel_e   rmw_addr_q;
  data_cycle_t dc;

  // Final access of a memory-operand instruction: plain read, plain write,
  // or the read half of a read-modify-write.
  function automatic data_cycle_t data_cycle(input logic rd, input logic wr);
    data_cycle_t r;
    r.we   = wr && !rd;
    r.last = !(rd && wr);
    r.next = (rd && wr) ? T_RMW1 : T0_FETCH;
    return r;
  endfunction

  // Only addressing modes this sequencer implements are accepted; the rest halt.
  function automatic t_state_e entry_state(input logic [5:0] code);
    t_state_e s;
    case (code)
      T0_FETCH, T2_ZPG, T2_ZPGXY, T2_ABS, T2_ABSXY, T2_PUSH, T2_POP:
        s = t_state_e'(code);
      default:
        s = T_JAM;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    o_sync    = 1'b0;
    o_ir_load = 1'b0;
    o_pc_inc  = 1'b0;
    addr_sel  = ADDR_PC;
    o_we      = 1'b0;
    o_sp_inc  = 1'b0;
    o_sp_dec  = 1'b0;
    o_last    = 1'b0;
    o_jam     = 1'b0;
    dc        = data_cycle(i_mem_read, i_mem_write);

    case (state_q)
      T0_FETCH: begin
        o_sync    = 1'b1;
        o_ir_load = 1'b1;
        o_pc_inc  = 1'b1;
        state_d   = T1_DECODE;
      end
      T1_DECODE: begin
        o_pc_inc = !i_single_byte;
        state_d  = entry_state(i_initial_state);
        o_last   = (state_d == T0_FETCH);
      end
      T2_ZPG: begin
        addr_sel = ADDR_ZP;
        o_we     = dc.we;
        o_last   = dc.last;
        state_d  = dc.next;
      end
      T2_ZPGXY: begin
        addr_sel = ADDR_ZP;
        state_d  = T3_ZPGXY;
      end
      T3_ZPGXY: begin
        addr_sel = ADDR_ZP_IDX;
        o_we     = dc.we;
        o_last   = dc.last;
        state_d  = dc.next;
      end
      T2_ABS: begin
        o_pc_inc = 1'b1;
        state_d  = T3_ABS;
      end
      T3_ABS: begin
        addr_sel = ADDR_ABS;
        o_we     = dc.we;
        o_last   = dc.last;
        state_d  = dc.next;
      end
      T2_ABSXY: begin
        o_pc_inc = 1'b1;
        state_d  = T3_ABSXY;
      end
      T3_ABSXY: begin
        addr_sel = ADDR_ABS_IDX;
        // Only an uncarried read may use the not-yet-fixed address.
        if (i_mem_read && !i_mem_write && !i_page_cross) begin
          o_last  = dc.last;
          state_d = dc.next;
        end else begin
          state_d = T4_ABSXY;
        end
      end
      T4_ABSXY: begin
        addr_sel = ADDR_ABS_FIX;
        o_we     = dc.we;
        o_last   = dc.last;
        state_d  = dc.next;
      end
      T_RMW1: begin
        addr_sel = rmw_addr_q;
        o_we     = 1'b1;
        state_d  = T_RMW2;
      end
      T_RMW2: begin
        addr_sel = rmw_addr_q;
        o_we     = 1'b1;
        o_last   = 1'b1;
        state_d  = T0_FETCH;
      end
      T2_PUSH: begin
        addr_sel = ADDR_STACK;
        o_we     = 1'b1;
        o_sp_dec = 1'b1;
        o_last   = 1'b1;
        state_d  = T0_FETCH;
      end
      T2_POP: begin
        addr_sel = ADDR_STACK;
        o_sp_inc = 1'b1;
        state_d  = T3_POP;
      end
      T3_POP: begin
        addr_sel = ADDR_STACK;
        o_last   = 1'b1;
        state_d  = T0_FETCH;
      end
      default: begin
        o_jam   = 1'b1;
        state_d = T_JAM;
      end
    endcase

    // Reads wait for the bus; writes always complete.
    if (!i_rdy && !o_we) begin
      state_d   = state_q;
      o_pc_inc  = 1'b0;
      o_ir_load = 1'b0;
      o_sp_inc  = 1'b0;
      o_sp_dec  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking so every register samples the values from before the edge.
    if (!i_rst_n) begin
      state_q    <= T0_FETCH;
      rmw_addr_q <= ADDR_PC;
    end else begin
      state_q <= state_d;
      // Hold the operand address through both RMW write cycles.
      if (state_q != T_RMW1 && state_q != T_RMW2)
        rmw_addr_q <= addr_sel;
    end
  end

  assign o_state    = state_q;
  assign o_addr_sel = addr_sel;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized scoreboard bench: a per-instruction timing-table model builds the
// expected cycle trace; a negedge monitor compares every DUT cycle against it.
module tb_cycle_sequencer;
  import cycle_sequencer_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_rdy, i_single_byte, i_mem_read, i_mem_write, i_page_cross;
  logic [5:0] i_initial_state;
  logic [5:0] o_state;
  logic [2:0] o_addr_sel;
  logic       o_sync, o_ir_load, o_pc_inc, o_we, o_sp_inc, o_sp_dec, o_last, o_jam;

  cycle_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rdy(i_rdy),
    .i_initial_state(i_initial_state), .i_single_byte(i_single_byte),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_page_cross(i_page_cross),
    .o_state(o_state), .o_sync(o_sync), .o_ir_load(o_ir_load), .o_pc_inc(o_pc_inc),
    .o_addr_sel(o_addr_sel), .o_we(o_we), .o_sp_inc(o_sp_inc), .o_sp_dec(o_sp_dec),
    .o_last(o_last), .o_jam(o_jam)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [5:0] state;
    logic       sync, ir_load, pc_inc;
    logic [2:0] addr;
    logic       we, sp_inc, sp_dec, last, jam;
  } obs_t;

  typedef struct {
    logic rdy;
    logic rst_n;
    obs_t exp;
  } step_t;

  typedef enum {M_IMPL, M_ZPG, M_ZPGXY, M_ABS, M_ABSXY, M_PUSH, M_POP, M_ILL} mode_e;

  typedef struct {
    mode_e      mode;
    logic       rd, wr, pc, single;
    logic [5:0] ill_code;
    int         wait_idx, wait_n;
    bit         rand_wait, wr_rdy_low;
    int         rst_idx, jam_cycles;
  } instr_t;

  obs_t  nom_q[$];
  step_t plan_q[$];
  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d sync=%0b irl=%0b pci=%0b addr=%0d we=%0b spi=%0b spd=%0b last=%0b jam=%0b",
                     o.state, o.sync, o.ir_load, o.pc_inc, o.addr, o.we, o.sp_inc, o.sp_dec,
                     o.last, o.jam);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  // One nominal (unstalled) bus cycle of the timing table.
  task automatic add(input t_state_e s, input addr_sel_e a, input bit we, input bit last,
                     input bit pci, input bit spi, input bit spd);
    obs_t o;
    o = '0;
    o.state = s; o.addr = a; o.we = we; o.last = last;
    o.pc_inc = pci; o.sp_inc = spi; o.sp_dec = spd;
    nom_q.push_back(o);
  endtask

  task automatic data(input t_state_e s, input addr_sel_e a, input logic rd, input logic wr);
    if (rd && wr) begin
      add(s, a, 0, 0, 0, 0, 0);
      add(T_RMW1, a, 1, 0, 0, 0, 0);
      add(T_RMW2, a, 1, 1, 0, 0, 0);
    end else if (wr) begin
      add(s, a, 1, 1, 0, 0, 0);
    end else begin
      add(s, a, 0, 1, 0, 0, 0);
    end
  endtask

  function automatic logic [5:0] code_of(input instr_t in);
    logic [5:0] c;
    case (in.mode)
      M_IMPL:  c = T0_FETCH;
      M_ZPG:   c = T2_ZPG;
      M_ZPGXY: c = T2_ZPGXY;
      M_ABS:   c = T2_ABS;
      M_ABSXY: c = T2_ABSXY;
      M_PUSH:  c = T2_PUSH;
      M_POP:   c = T2_POP;
      default: c = in.ill_code;
    endcase
    return c;
  endfunction

  // Expand an instruction into its per-cycle plan: nominal timing table,
  // then RDY wait cycles in front of read cycles, then optional reset cut-off.
  task automatic build(input instr_t in);
    obs_t  o;
    step_t st;
    int    w;
    nom_q.delete();
    plan_q.delete();
    o = '0; o.state = T0_FETCH; o.sync = 1; o.ir_load = 1; o.pc_inc = 1; o.addr = ADDR_PC;
    nom_q.push_back(o);
    add(T1_DECODE, ADDR_PC, 0, in.mode == M_IMPL, !in.single, 0, 0);
    case (in.mode)
      M_ZPG:   data(T2_ZPG, ADDR_ZP, in.rd, in.wr);
      M_ZPGXY: begin
        add(T2_ZPGXY, ADDR_ZP, 0, 0, 0, 0, 0);
        data(T3_ZPGXY, ADDR_ZP_IDX, in.rd, in.wr);
      end
      M_ABS: begin
        add(T2_ABS, ADDR_PC, 0, 0, 1, 0, 0);
        data(T3_ABS, ADDR_ABS, in.rd, in.wr);
      end
      M_ABSXY: begin
        add(T2_ABSXY, ADDR_PC, 0, 0, 1, 0, 0);
        if (in.rd && !in.wr && !in.pc) data(T3_ABSXY, ADDR_ABS_IDX, in.rd, in.wr);
        else begin
          add(T3_ABSXY, ADDR_ABS_IDX, 0, 0, 0, 0, 0);
          data(T4_ABSXY, ADDR_ABS_FIX, in.rd, in.wr);
        end
      end
      M_PUSH: add(T2_PUSH, ADDR_STACK, 1, 1, 0, 0, 1);
      M_POP: begin
        add(T2_POP, ADDR_STACK, 0, 0, 0, 1, 0);
        add(T3_POP, ADDR_STACK, 0, 1, 0, 0, 0);
      end
      M_ILL: begin
        for (int j = 0; j < in.jam_cycles; j++) begin
          o = '0; o.state = T_JAM; o.addr = ADDR_PC; o.jam = 1;
          nom_q.push_back(o);
        end
      end
      default: ;
    endcase

    foreach (nom_q[k]) begin
      st.exp = nom_q[k];
      st.rst_n = 1'b1;
      if (!nom_q[k].we) begin
        w = 0;
        if (k == in.wait_idx) w = in.wait_n;
        else if (in.rand_wait && $urandom_range(3) == 0) w = int'($urandom_range(2, 1));
        if (k == in.rst_idx) w = 0;
        for (int j = 0; j < w; j++) begin
          st.rdy = 1'b0;
          st.exp = nom_q[k];
          st.exp.pc_inc = 0; st.exp.ir_load = 0; st.exp.sp_inc = 0; st.exp.sp_dec = 0;
          plan_q.push_back(st);
        end
        st.rdy = 1'b1;
      end else begin
        st.rdy = in.wr_rdy_low ? 1'b0 : 1'($urandom_range(1));
      end
      st.exp = nom_q[k];
      if (k == in.rst_idx) begin
        st.rst_n = 1'b0;
        st.rdy = 1'b1;
      end
      plan_q.push_back(st);
      if (k == in.rst_idx) break;
    end
  endtask

  task automatic run(input instr_t in);
    build(in);
    foreach (plan_q[k]) begin
      @(posedge i_clk);
      #1;
      i_rst_n         = plan_q[k].rst_n;
      i_rdy           = plan_q[k].rdy;
      i_initial_state = code_of(in);
      i_single_byte   = in.single;
      i_mem_read      = in.rd;
      i_mem_write     = in.wr;
      i_page_cross    = in.pc;
      exp_q.push_back(plan_q[k].exp);
    end
  endtask

  function automatic instr_t mk(input mode_e m, input logic rd, input logic wr,
                                input logic pc, input logic single);
    instr_t in;
    in.mode = m; in.rd = rd; in.wr = wr; in.pc = pc; in.single = single;
    in.ill_code = T_JAM; in.wait_idx = -1; in.wait_n = 0; in.rand_wait = 0;
    in.wr_rdy_low = 0; in.rst_idx = -1; in.jam_cycles = 0;
    return in;
  endfunction

  // Monitor: every cycle with an outstanding expectation is compared.
  always @(negedge i_clk) begin
    obs_t got, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {o_state, o_sync, o_ir_load, o_pc_inc, o_addr_sel, o_we, o_sp_inc, o_sp_dec,
             o_last, o_jam};
      check($sformatf("cycle%0d", step_no), got, e);
      step_no++;
    end
  end

  initial begin
    instr_t     in;
    logic [5:0] ill_codes[10];
    int         wait_budget;
    ill_codes = '{T2_BRK, T2_JSR, T2_RTI, T2_RTS, T2_XIND, T2_INDY, T2_BRANCH, T2_JUMP,
                  T_JAM, T1_DECODE};
    i_rst_n = 1'b0; i_rdy = 1'b1; i_initial_state = '0; i_single_byte = 1'b0;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_page_cross = 1'b0;
    repeat (2) @(posedge i_clk);

    run(mk(M_ZPG, 1, 0, 0, 0));                       // LDA zpg
    run(mk(M_ABSXY, 1, 0, 0, 0));                     // LDA abs,X no carry
    run(mk(M_ABSXY, 1, 0, 1, 0));                     // LDA abs,X carry
    run(mk(M_ABSXY, 0, 1, 0, 0));                     // STA abs,X
    in = mk(M_ZPG, 1, 1, 0, 0); in.wr_rdy_low = 1;    // INC zpg, rdy low on writes
    run(in);
    run(mk(M_PUSH, 0, 1, 0, 1));                      // PHA
    run(mk(M_POP, 1, 0, 0, 1));                       // PLA
    in = mk(M_ABS, 1, 0, 0, 0); in.wait_idx = 3; in.wait_n = 3;  // LDA abs, stall T3
    run(in);
    in = mk(M_ZPG, 1, 1, 0, 0); in.rst_idx = 3;       // INC zpg, reset in T_RMW1
    run(in);
    run(mk(M_IMPL, 1, 0, 0, 1));                      // implied, 2 cycles
    in = mk(M_ILL, 0, 0, 0, 1); in.jam_cycles = 20; in.rst_idx = 21;  // opcode 02
    run(in);

    for (int n = 0; n < 80; n++) begin
      in = mk(mode_e'($urandom_range(7)), 1'b0, 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)));
      in.rd = !in.wr || 1'($urandom_range(1));
      in.rand_wait = 1;
      if (in.mode == M_ILL) begin
        in.ill_code = ill_codes[$urandom_range(9)];
        in.jam_cycles = 3;
        in.rst_idx = 4;
      end
      run(in);
    end

    wait_budget = 10;
    while (exp_q.size() > 0 && wait_budget > 0) begin
      @(posedge i_clk);
      wait_budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
